// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: the raw pin going in, and the qualified
// level, long-press flag and debug state coming out.
interface button_debouncer_if;
  logic       btn_raw;
  logic       btn_level;
  logic       btn_long;
  logic [1:0] btn_state;

  // Board / stimulus side: drives the pin, observes the qualified outputs.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_long,
    input  btn_state
  );

  // Debouncer side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_long,
    output btn_state
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer.
// The raw pin is normalised to active-high and passed through a two-flop
// synchroniser. A four-state FSM then requires DEBOUNCE_CYCLES consecutive
// stable samples before it changes the qualified level. A hold counter,
// started when the level rises, flags a long press after LONG_CYCLES. The
// hold counter keeps running through release bounce, so a bounce during
// release does not restart long-press timing.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  button_debouncer_if.slave bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // The hold counter saturates at LONG_CYCLES so a very long press never wraps.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
    return (h >= HOLD_MAX) ? h : h + HOLD_W'(1);
  endfunction

  logic pin_pressed;
  logic sync_p0;
  logic sync_p1;
  logic p_s;

  state_t              state_q, state_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                level_q, level_d;
  logic                long_q, long_d;

  assign pin_pressed = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;
  assign p_s         = sync_p1;

  // Synchronise the normalised pin into the clk domain; reset to "not pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin_pressed;
      sync_p1 <= sync_p0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      deb_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      long_q  <= long_d;
    end
  end

  // Next-state logic: qualify presses and releases, time the long press.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    level_d = level_q;
    long_d  = long_q;
    case (state_q)
      RELEASED: begin
        level_d = 1'b0;
        long_d  = 1'b0;
        hold_d  = '0;
        if (p_s) begin
          state_d = PRESS_WAIT;
          deb_d   = DEB_ONE;
        end else begin
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p_s) begin
          state_d = RELEASED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          hold_d  = '0;
          deb_d   = '0;
        end else begin
          deb_d   = deb_q + DEB_ONE;
        end
      end
      PRESSED: begin
        hold_d = hold_inc(hold_q);
        if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end
        if (!p_s) begin
          state_d = RELEASE_WAIT;
          deb_d   = DEB_ONE;
        end
      end
      RELEASE_WAIT: begin
        hold_d = hold_inc(hold_q);
        if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end
        if (p_s) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          long_d  = 1'b0;
          hold_d  = '0;
          deb_d   = '0;
        end else begin
          deb_d   = deb_q + DEB_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        deb_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
        long_d  = 1'b0;
      end
    endcase
  end

  assign bus.btn_level = level_q;
  assign bus.btn_long  = long_q;
  assign bus.btn_state = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10,
// active-low pin. Directed sequences cover reset, clean/bouncy/short presses,
// release bounce and asynchronous reset; a random pin pattern is then checked
// against a window-based reference model.
module tb_button_debouncer;

  localparam int DEB = 4;
  localparam int LNG = 10;

  logic clk = 1'b0;
  logic rst_n;

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: level flips when the last DEB synchronised samples all
  // disagree with it; long is set once the level has been high for LNG edges.
  bit pipe0, pipe1;
  bit win[$];
  bit m_level, m_long, m_last_ps;
  int m_age;

  typedef struct {
    bit         raw;
    bit         level;
    bit         lng;
    logic [1:0] state;
  } vec_t;

  vec_t t2[28];

  task automatic model_reset();
    pipe0 = 1'b0;
    pipe1 = 1'b0;
    win.delete();
    m_level   = 1'b0;
    m_long    = 1'b0;
    m_last_ps = 1'b0;
    m_age     = 0;
  endtask

  task automatic model_edge(input bit pn);
    bit ps;
    bit flip;
    ps    = pipe1;
    pipe1 = pipe0;
    pipe0 = pn;
    win.push_back(ps);
    if (win.size() > DEB) void'(win.pop_front());
    m_last_ps = ps;
    flip = (win.size() == DEB);
    foreach (win[i]) if (win[i] == m_level) flip = 1'b0;
    if (flip) begin
      m_level = !m_level;
      m_long  = 1'b0;
      m_age   = 0;
    end else if (m_level) begin
      m_age++;
      if (m_age >= LNG) m_long = 1'b1;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_level) return m_last_ps ? 2'd2 : 2'd3;
    else         return m_last_ps ? 2'd1 : 2'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive the pin, take the edge, update the model, settle.
  task automatic tick(input bit raw);
    bif.btn_raw = raw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(~raw);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 28; i++) begin
      int e;
      e = i + 1;
      t2[i].raw   = (e <= 20) ? 1'b0 : 1'b1;
      t2[i].state = (e < 3)  ? 2'd0 :
                    (e < 6)  ? 2'd1 :
                    (e < 23) ? 2'd2 :
                    (e < 26) ? 2'd3 : 2'd0;
      t2[i].level = (e >= 6)  && (e < 26);
      t2[i].lng   = (e >= 16) && (e < 26);
    end

    rst_n = 1'b0;
    bif.btn_raw = 1'b0;
    model_reset();

    // Reset held with the button pressed, then requalify from scratch.
    repeat (3) tick(1'b0);
    check("rst_level", bif.btn_level, 0);
    check("rst_long",  bif.btn_long,  0);
    check("rst_state", bif.btn_state, 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1'b0);
      check($sformatf("t1_level_e%0d", e), bif.btn_level, (e >= 6) ? 1 : 0);
    end
    repeat (12) tick(1'b1);
    check("t1_idle_state", bif.btn_state, 0);
    check("t1_idle_level", bif.btn_level, 0);

    // Clean press held 20 cycles, then clean release.
    for (int i = 0; i < 28; i++) begin
      tick(t2[i].raw);
      check($sformatf("t2_state_e%0d", i + 1), bif.btn_state, t2[i].state);
      check($sformatf("t2_level_e%0d", i + 1), bif.btn_level, t2[i].level);
      check($sformatf("t2_long_e%0d",  i + 1), bif.btn_long,  t2[i].lng);
    end
    repeat (4) tick(1'b1);

    // Bouncy press: 0,1,0,1 then stable 0 from edge 5; rise on edge 10.
    for (int e = 1; e <= 14; e++) begin
      bit r;
      r = (e <= 4) ? ((e % 2) == 0) : 1'b0;
      tick(r);
      check($sformatf("t3_level_e%0d", e), bif.btn_level, (e >= 10) ? 1 : 0);
    end
    repeat (12) tick(1'b1);
    check("t3_idle_state", bif.btn_state, 0);

    // Short press: 3 pressed samples are not enough.
    for (int e = 1; e <= 10; e++) begin
      tick((e <= 3) ? 1'b0 : 1'b1);
      check($sformatf("t4_level_e%0d", e), bif.btn_level, 0);
      if (e == 3)  check("t4_state_wait", bif.btn_state, 1);
      if (e == 10) check("t4_state_end",  bif.btn_state, 0);
    end
    repeat (4) tick(1'b1);

    // Release bounce: pin released for 2 samples during PRESSED.
    for (int e = 1; e <= 18; e++) begin
      tick((e == 9 || e == 10) ? 1'b1 : 1'b0);
      if (e >= 6) check($sformatf("t5_level_e%0d", e), bif.btn_level, 1);
      if (e == 11 || e == 12) check($sformatf("t5_state_e%0d", e), bif.btn_state, 3);
      if (e == 13) check("t5_state_back", bif.btn_state, 2);
      if (e == 15) check("t5_long_e15", bif.btn_long, 0);
      if (e == 16) check("t5_long_e16", bif.btn_long, 1);
    end
    repeat (12) tick(1'b1);
    check("t5_idle_state", bif.btn_state, 0);
    check("t5_idle_long",  bif.btn_long,  0);

    // Asynchronous reset during RELEASE_WAIT with long asserted.
    repeat (20) tick(1'b0);
    repeat (3) tick(1'b1);
    check("t6_pre_state", bif.btn_state, 3);
    check("t6_pre_long",  bif.btn_long,  1);
    check("t6_pre_level", bif.btn_level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_level", bif.btn_level, 0);
    check("t6_async_long",  bif.btn_long,  0);
    check("t6_async_state", bif.btn_state, 0);
    tick(1'b1);
    rst_n = 1'b1;

    // Random pin activity against the reference model.
    begin
      int remaining;
      bit r;
      remaining = 0;
      r = 1'b1;
      for (int c = 0; c < 900; c++) begin
        if (remaining == 0) begin
          r = ~r;
          remaining = $urandom_range(1, 14);
        end
        remaining--;
        if (c == 450) rst_n = 1'b0;
        if (c == 452) rst_n = 1'b1;
        tick(r);
        check($sformatf("rnd_level_c%0d", c), bif.btn_level, m_level);
        check($sformatf("rnd_long_c%0d",  c), bif.btn_long,  m_long);
        check($sformatf("rnd_state_c%0d", c), bif.btn_state, model_state());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Qualifies one raw push-button pin into a clean, clk-synchronous level.
- The level asserts only after the pin has been stable pressed for DEBOUNCE_CYCLES, and releases only after it has been stable released for DEBOUNCE_CYCLES.
- Flags a long press once the qualified press has lasted LONG_CYCLES.
- Sits directly upstream of rising_edge_detector: btn_level drives its input, so one press yields one downstream pulse.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to change state (20 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50000000, cycles from btn_level rise to btn_long assertion; must be >= 1.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board KEYs); 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- btn_raw  input  1  asynchronous button pin
- btn_level  output  1  debounced pressed level, active-high
- btn_long  output  1  high while a qualified press has lasted >= LONG_CYCLES
- btn_state  output  2  FSM state, for debug/LEDs

Behaviour:
Reset:
- rst_n low immediately forces state RELEASED (encoding 0), both counters 0, sync flops to the "not pressed" value, and btn_level = 0, btn_long = 0.
- Reset asserted mid-press or mid-bounce abandons all counting.
- After reset release, a held button must requalify from scratch.

Input conditioning:
- btn_raw is normalised by ACTIVE_LOW (inverted when 1).
- Then passed through an internal 2-flop synchroniser to give p_s; the FSM sees only p_s.

Counters:
- deb_cnt: width $clog2(DEBOUNCE_CYCLES+1).
- hold_cnt: width $clog2(LONG_CYCLES+1); saturates at LONG_CYCLES and never wraps.

FSM states (btn_state encoding):
- RELEASED (0): btn_level = 0. If p_s = 1, go to PRESS_WAIT with deb_cnt = 1.
- PRESS_WAIT (1):
  - If p_s = 0, return to RELEASED with deb_cnt = 0; any bounce restarts qualification.
  - Else deb_cnt increments.
  - On the edge where deb_cnt = DEBOUNCE_CYCLES-1 and p_s = 1, go to PRESSED: btn_level = 1, hold_cnt = 0, deb_cnt = 0.
- PRESSED (2):
  - hold_cnt increments each cycle; btn_long is set on the edge where hold_cnt reaches LONG_CYCLES-1.
  - If p_s = 0, go to RELEASE_WAIT with deb_cnt = 1.
- RELEASE_WAIT (3):
  - btn_level stays 1, and hold_cnt keeps counting, so release bounce does not reset long-press timing.
  - If p_s = 1, return to PRESSED with deb_cnt = 0.
  - On the edge where deb_cnt = DEBOUNCE_CYCLES-1 and p_s = 0, go to RELEASED: btn_level = 0, btn_long = 0, hold_cnt = 0.

Latency and timing:
- For a clean press, with edge 1 being the first edge sampling the pressed pin, btn_level is high after edge DEBOUNCE_CYCLES+2.
- Release has the same latency.
- btn_long rises LONG_CYCLES edges after btn_level rises.
- btn_long falls on the same edge as btn_level.
- btn_long may rise during RELEASE_WAIT.
- All outputs are registered, with no combinational path from btn_raw.
- btn_level changes at most once per DEBOUNCE_CYCLES cycles.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
1. Reset held with btn_raw=0 (pressed), then release rst_n -> btn_level=0 and btn_long=0 during reset; btn_level rises exactly 6 edges after the first post-reset edge.
2. Clean press (btn_raw 1->0, held 20 cycles) -> btn_level=1 after edge 6; btn_state passes 1 then 2; btn_long rises 10 edges later (edge 16).
3. Bouncy press (btn_raw toggles 0,1,0,1 on single cycles, then stable 0) -> no btn_level glitch; btn_level rises 6 edges after the final stable-0 sample.
4. Short press (stable 0 for 3 cycles, then 1) -> btn_level stays 0 and btn_state returns to 0.
5. Release bounce (during PRESSED, btn_raw=1 for 2 cycles then 0) -> btn_state goes 3 then back to 2; btn_level stays 1; hold_cnt is not reset, so btn_long timing is unchanged.
6. Assert rst_n low during RELEASE_WAIT with btn_long=1 -> btn_level=0, btn_long=0 and btn_state=0 asynchronously, before the next clk edge.
